// File: rtl/wb_conbus_rr_if.sv
// Bus bundle for wb_conbus_rr: every master-side and slave-side Wishbone signal of the shared bus.
// The slave modport is the interconnect's view; the master modport is the environment that drives it.
interface wb_conbus_rr_if #(
    parameter int NM = 2,
    parameter int NS = 5,
    parameter int AW = 32,
    parameter int DW = 32
);
    // master side
    logic [NM*DW-1:0]     m_dat_i;
    logic [NM*AW-1:0]     m_adr_i;
    logic [NM*3-1:0]      m_cti_i;
    logic [NM*(DW/8)-1:0] m_sel_i;
    logic [NM-1:0]        m_we_i;
    logic [NM-1:0]        m_cyc_i;
    logic [NM-1:0]        m_stb_i;
    logic [NM*DW-1:0]     m_dat_o;
    logic [NM-1:0]        m_ack_o;
    logic [NM-1:0]        m_err_o;
    // slave side
    logic [NS*DW-1:0]     s_dat_o;
    logic [NS*AW-1:0]     s_adr_o;
    logic [NS*3-1:0]      s_cti_o;
    logic [NS*(DW/8)-1:0] s_sel_o;
    logic [NS-1:0]        s_we_o;
    logic [NS-1:0]        s_cyc_o;
    logic [NS-1:0]        s_stb_o;
    logic [NS*DW-1:0]     s_dat_i;
    logic [NS-1:0]        s_ack_i;
    logic [NS-1:0]        s_err_i;

    modport slave (
        input  m_dat_i, m_adr_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_dat_o, s_adr_o, s_cti_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        input  s_dat_i, s_ack_i, s_err_i
    );

    modport master (
        output m_dat_i, m_adr_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_dat_o, s_adr_o, s_cti_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i, s_err_i
    );
endinterface

// File: rtl/wb_conbus_rr.sv
// Shared-bus Wishbone interconnect: round-robin master arbitration held for the whole cyc,
// base/mask slave decode, bus error on unmapped accesses and on slave time-out.
module wb_conbus_rr #(
    parameter int               NM         = 2,
    parameter int               NS         = 5,
    parameter int               AW         = 32,
    parameter int               DW         = 32,
    parameter logic [NS*AW-1:0] SLAVE_BASE = '0,
    parameter logic [NS*AW-1:0] SLAVE_MASK = {NS{{3'b111, {(AW-3){1'b0}}}}},
    parameter int               TIMEOUT    = 255
) (
    input logic           sys_clk,
    input logic           sys_rst_n,
    wb_conbus_rr_if.slave bus
);
    localparam int SELW = DW / 8;
    localparam int GW   = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW   = (NS > 1) ? $clog2(NS) : 1;
    localparam int WDW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gnt_idx_q, gnt_idx_d;
    logic [GW-1:0]   last_idx_q, last_idx_d;
    logic [WDW-1:0]  wd_cnt_q, wd_cnt_d;
    logic            err_pend_q, err_pend_d;

    logic            gnt_valid;
    logic [AW-1:0]   g_adr;
    logic [DW-1:0]   g_dat;
    logic [SELW-1:0] g_sel;
    logic [2:0]      g_cti;
    logic            g_we, g_cyc, g_stb;
    logic            req_cyc, req_stb;
    logic            hit_any;
    logic [SW-1:0]   hit_idx;
    logic            sl_ack, sl_err, resp;
    logic [DW-1:0]   sl_dat;
    logic            wd_run, wd_expire;
    logic [NS-1:0]   s_cyc, s_stb;
    logic [NM-1:0]   m_ack, m_err;

    assign gnt_valid = (state_q == OWNED);

    always_comb begin
        g_adr = bus.m_adr_i[gnt_idx_q*AW +: AW];
        g_dat = bus.m_dat_i[gnt_idx_q*DW +: DW];
        g_sel = bus.m_sel_i[gnt_idx_q*SELW +: SELW];
        g_cti = bus.m_cti_i[gnt_idx_q*3 +: 3];
        g_we  = bus.m_we_i[gnt_idx_q];
        g_cyc = bus.m_cyc_i[gnt_idx_q];
        g_stb = bus.m_stb_i[gnt_idx_q];
    end

    assign req_cyc = gnt_valid & g_cyc;
    assign req_stb = req_cyc & g_stb;

    // Scan downwards so the lowest matching slave index is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if ((g_adr & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW]) begin
                hit_any = 1'b1;
                hit_idx = SW'(k);
            end
        end
    end

    assign sl_ack = hit_any & bus.s_ack_i[hit_idx];
    assign sl_err = hit_any & bus.s_err_i[hit_idx];
    assign sl_dat = (gnt_valid && hit_any) ? bus.s_dat_i[hit_idx*DW +: DW] : '0;
    assign resp   = sl_ack | sl_err | err_pend_q;

    // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.m_cyc_i) begin
                    state_d = OWNED;
                    // Walk from farthest to nearest so the first requester after last_idx wins.
                    for (int i = NM; i >= 1; i--) begin
                        if (bus.m_cyc_i[(int'(last_idx_q) + i) % NM]) begin
                            gnt_idx_d = GW'((int'(last_idx_q) + i) % NM);
                        end
                    end
                end
            end
            OWNED: begin
                if (!g_cyc) begin
                    state_d    = IDLE;
                    last_idx_d = gnt_idx_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A coincident slave response suppresses the expiry, so a late ack still beats the watchdog.
    always_comb begin
        wd_run    = req_stb & hit_any & ~resp;
        wd_expire = (TIMEOUT != 0) && wd_run && (wd_cnt_q == WDW'(TIMEOUT - 1));
        wd_cnt_d  = '0;
        if ((TIMEOUT != 0) && wd_run && !wd_expire) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        err_pend_d = (req_stb & ~hit_any & ~err_pend_q) | wd_expire;
    end

    // Responses are only forwarded while the owner is strobing, so a stale ack after an error is dropped.
    always_comb begin
        m_ack = '0;
        m_err = '0;
        for (int k = 0; k < NS; k++) begin
            s_cyc[k] = req_cyc & hit_any & (hit_idx == SW'(k));
            s_stb[k] = req_stb & hit_any & (hit_idx == SW'(k));
        end
        if (req_stb) begin
            m_ack[gnt_idx_q] = sl_ack;
            m_err[gnt_idx_q] = sl_err | err_pend_q;
        end
    end

    assign bus.s_cyc_o = s_cyc;
    assign bus.s_stb_o = s_stb;
    assign bus.s_adr_o = gnt_valid ? {NS{g_adr}} : '0;
    assign bus.s_dat_o = gnt_valid ? {NS{g_dat}} : '0;
    assign bus.s_sel_o = gnt_valid ? {NS{g_sel}} : '0;
    assign bus.s_cti_o = gnt_valid ? {NS{g_cti}} : '0;
    assign bus.s_we_o  = gnt_valid ? {NS{g_we}}  : '0;
    assign bus.m_ack_o = m_ack;
    assign bus.m_err_o = m_err;
    assign bus.m_dat_o = {NM{sl_dat}};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            gnt_idx_q  <= '0;
            last_idx_q <= GW'(NM - 1);
            wd_cnt_q   <= '0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
            wd_cnt_q   <= wd_cnt_d;
            err_pend_q <= err_pend_d;
        end
    end
endmodule

// File: doc/wb_conbus_rr.md
# wb_conbus_rr

Parametrised Wishbone shared-bus interconnect for the SoC: NM masters, NS slaves, one transfer path at a time. Masters are arbitrated round-robin, and the grant is held for the whole cyc. Addresses are decoded against per-slave base/mask parameters. Unmapped accesses and slave time-outs return a bus error, which the fixed-priority, fixed-decode predecessor did not do. The block sits between the CPU/DMA masters and the peripheral/memory slaves.

## Interface
- NM, 2, number of masters (1..8)
- NS, 5, number of slaves (1..16)
- AW, 32, address width
- DW, 32, data width; select width is DW/8
- SLAVE_BASE, {NS{AW'h0}}, packed NS*AW base addresses, slave i at [i*AW +: AW]
- SLAVE_MASK, {NS{AW'hE000_0000}}, packed NS*AW masks; slave i hit when (adr & mask_i) == base_i
- TIMEOUT, 255, cycles of stb without ack/err before the error response; 0 disables the watchdog
- sys_clk  in  1  clock, rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- m_dat_i / m_adr_i  in  NM*DW / NM*AW  master write data / address, master j at [j*W +: W]
- m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i  in  NM*3, NM*DW/8, NM, NM, NM  master controls
- m_dat_o  out  NM*DW  read data; the same value is broadcast to all masters
- m_ack_o, m_err_o  out  NM, NM  qualified by grant
- s_dat_o / s_adr_o / s_cti_o / s_sel_o / s_we_o  out  NS*DW / NS*AW / NS*3 / NS*DW/8 / NS  broadcast from the granted master
- s_cyc_o, s_stb_o  out  NS, NS  asserted only for the decoded slave
- s_dat_i, s_ack_i, s_err_i  in  NS*DW, NS, NS  slave responses

## Operation
- Registers:
  - gnt_valid
  - gnt_idx[clog2(NM)-1:0]
  - last_idx, the most recent owner
  - wd_cnt, the watchdog counter, ceil(log2(TIMEOUT+1)) bits
  - err_pend
- States: IDLE (gnt_valid=0) and OWNED (gnt_valid=1).
  - IDLE -> OWNED when any m_cyc_i is high. gnt_idx is set to the first requester scanning last_idx+1, last_idx+2, ... modulo NM.
  - OWNED -> IDLE when m_cyc_i[gnt_idx] is low at an edge. last_idx is set to gnt_idx.
  - There is no re-arbitration while the owner holds cyc; locked/burst cycles are implicitly atomic.
- Decode: combinational on the granted address. The lowest slave index wins on overlap. If no slave matches, no s_cyc_o is raised.
- Slave path: s_cyc_o[k] = gnt_valid & m_cyc_i[g] & sel[k], and s_stb_o[k] likewise with stb.
- Master path: m_ack_o[g] = s_ack_i[k]. m_err_o[g] = s_err_i[k] | err_pend. m_dat_o = s_dat_i[k], or 0 when unmapped. All other masters see ack=err=0.
- Unmapped access: err_pend is set at the first edge with a granted stb and no hit, then cleared at the next edge. This gives a one-cycle error.
- Watchdog:
  - wd_cnt increments each edge while the granted stb is high, a hit exists and there is no ack/err.
  - It clears on ack, err, stb low or a grant change.
  - When wd_cnt == TIMEOUT-1 and there is still no response, err_pend is set for one cycle.
  - It is disabled when TIMEOUT = 0.

## Timing
- Reset (asynchronous, sys_rst_n=0):
  - gnt_valid=0, gnt_idx=0, last_idx=NM-1 (so master 0 wins first), wd_cnt=0, err_pend=0.
  - Consequently every s_cyc_o, s_stb_o, m_ack_o and m_err_o is 0. Data/address outputs are 0 while no grant exists.
- Grant latency: a request at edge T is granted after edge T. s_cyc_o/s_stb_o are visible in cycle T+1.
- Ack/err/data: combinational slave->master, zero added latency.
- Release: owner drops cyc at edge T, and the next requester is granted after edge T+1. This leaves one dead cycle between owners.
- Simultaneous requests: strict round-robin from last_idx. A master requesting continuously gets at most one tenure per NM tenures when the others also request.
- Reset mid-transfer: the grant is dropped immediately and s_cyc_o falls asynchronously. A pending err_pend is discarded.
- Slave ack coincident with the watchdog expiry edge: the ack wins and no error is issued.

## Test plan
- Reset, then master 0 reads 0x0000_0010 (slave 0 base 0, mask E000_0000):
  - s_cyc_o[0]=1 one cycle after m_cyc_i[0].
  - Slave acks with 0xDEADBEEF, so m_ack_o[0]=1 and m_dat_o=0xDEADBEEF in the same cycle.
- Masters 0 and 1 both request from reset:
  - Master 0 is granted first.
  - On its release, after the dead cycle, master 1 is granted.
  - After master 1 releases, master 0 is granted again with both still requesting.
- Master 1 holds cyc over 4 single transfers while master 0 requests: master 0 is never granted until master 1's cyc drops.
- Access to 0xF000_0000 with no matching slave: no s_cyc_o is asserted, and m_err_o=1 for exactly one cycle, one cycle after stb.
- TIMEOUT=8, slave never acks: m_err_o=1 for one cycle, 8 cycles after stb is first seen at the slave. The slave's late ack after the error is not forwarded once stb is dropped.
- sys_rst_n pulsed low mid-burst: all s_cyc_o drop immediately. After release, master 0 regains priority.
